// File: rtl/cpstr_pkg.sv
// Shared definitions for the control-stream escaper, RX demux and manager.
// Holds the default escape/command bytes and the escape FSM state type.
package cpstr_pkg;

    localparam logic [7:0] CPSTR_ESC            = 8'h1B;
    localparam logic [7:0] CPSTR_CMD_STRIDX_REQ = 8'hFF;

    typedef enum logic {
        S_DATA,
        S_ESC
    } cpstr_state_e;

    // Stream index width; a single stream still gets a 1-bit index.
    function automatic int cpstr_stridx_w(input int n_streams);
        return (n_streams > 2) ? $clog2(n_streams) : 1;
    endfunction

endpackage

// File: rtl/cpstr_rx_oreg.sv
// One-entry ready/valid output register for the RX demux.
// Holds its contents under back-pressure and accepts a new load whenever it drains.
module cpstr_rx_oreg #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    assign o_ready = !valid_q || i_ready;
    assign o_valid = valid_q;
    assign o_data  = data_q;

    // A load replaces the entry; otherwise it empties once the consumer takes it.
    always_comb begin
        valid_d = valid_q && !i_ready;
        data_d  = data_q;
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/cpstr_rx_demux.sv
// RX control-stream demux: strips escapes, decodes escape commands and tags
// each payload byte with the currently selected stream index.
module cpstr_rx_demux
    import cpstr_pkg::*;
#(
    parameter logic [7:0] ESC_CHAR       = CPSTR_ESC,
    parameter logic [7:0] CMD_STRIDX_REQ = CPSTR_CMD_STRIDX_REQ,
    parameter int         N_STREAMS      = 4,
    localparam int        STRIDX_W       = cpstr_stridx_w(N_STREAMS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [7:0]          i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [7:0]          o_data,
    output logic [STRIDX_W-1:0] o_tid,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [STRIDX_W-1:0] o_stridx,
    output logic                o_stridx_upd,
    output logic                o_send_stridx,
    output logic                o_err
);

    localparam logic [7:0] N_LIMIT = 8'(N_STREAMS);

    cpstr_state_e          state_q, state_d;
    logic [STRIDX_W-1:0]   stridx_q, stridx_d;
    logic                  upd_q, upd_d;
    logic                  send_q, send_d;
    logic                  err_q, err_d;
    logic                  load;
    logic                  hs;
    logic                  is_esc, is_req, is_sel;
    logic [STRIDX_W+7:0]   oreg_data;

    assign hs     = i_valid && o_ready;
    assign is_esc = (i_data == ESC_CHAR);
    assign is_req = (i_data == CMD_STRIDX_REQ);
    assign is_sel = (i_data < N_LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (hs) begin
            state_d = (state_q == S_DATA && is_esc) ? S_ESC : S_DATA;
        end
    end

    // Command decode; the escaped byte's meaning is checked in priority order.
    always_comb begin
        load     = 1'b0;
        stridx_d = stridx_q;
        upd_d    = 1'b0;
        send_d   = 1'b0;
        err_d    = 1'b0;
        if (hs) begin
            case (state_q)
                S_DATA: load = !is_esc;
                S_ESC: begin
                    if (is_esc) begin
                        load = 1'b1;
                    end else if (is_req) begin
                        send_d = 1'b1;
                    end else if (is_sel) begin
                        stridx_d = i_data[STRIDX_W-1:0];
                        upd_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stridx_q <= '0;
            upd_q    <= 1'b0;
            send_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            stridx_q <= stridx_d;
            upd_q    <= upd_d;
            send_q   <= send_d;
            err_q    <= err_d;
        end
    end

    assign o_stridx      = stridx_q;
    assign o_stridx_upd  = upd_q;
    assign o_send_stridx = send_q;
    assign o_err         = err_q;

    // The tag is the index in force when the byte is accepted, not when it leaves.
    cpstr_rx_oreg #(
        .W(STRIDX_W + 8)
    ) u_oreg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (load),
        .i_data  ({stridx_q, i_data}),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (oreg_data),
        .i_ready (i_ready)
    );

    assign {o_tid, o_data} = oreg_data;

endmodule
